// File: rtl/jt12_bus_seq_pkg.sv
// jt12_bus_seq_pkg: shared types and constants for the jt12 write sequencer.
//   state_t  : sequencer FSM states (S_WAIT only reachable with JT12_BUS_SEQ_RANDWAIT_EN)
//   cmd_t    : queued command {bank, regn, val}
//   LFSR_SEED/LFSR_TAPS : 16-bit Fibonacci LFSR (taps 16,14,13,11)
package jt12_bus_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AWR   = 3'd1,
        S_AGAP  = 3'd2,
        S_POLL1 = 3'd3,
        S_DWR   = 3'd4,
        S_DGAP  = 3'd5,
        S_POLL2 = 3'd6,
        S_WAIT  = 3'd7
    } state_t;

    typedef struct packed {
        logic       bank;
        logic [7:0] regn;
        logic [7:0] val;
    } cmd_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Bit mask of taps 16,14,13,11 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/jt12_bus_seq_if.sv
// jt12_bus_seq_if: jt12 CPU-side register bus.
//   cs_n  chip select (active-low)     wr_n  write strobe (active-low)
//   addr  {bank, data_phase}           dout  write data
//   din   status read, din[7] = busy
// master: the sequencer driving the bus; slave: the jt12 side.
interface jt12_bus_seq_if;
    logic       cs_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] dout;
    logic [7:0] din;

    modport master (output cs_n, output wr_n, output addr, output dout, input din);
    modport slave  (input cs_n, input wr_n, input addr, input dout, output din);
endinterface

// File: rtl/jt12_bus_seq_fifo.sv
// jt12_bus_seq_fifo: synchronous command FIFO with DEPTH entries.
//   push/pop : requests; push ignored when full, pop ignored when empty
//   din/dout : entry in / head entry out (dout valid while !empty)
//   full, empty, level : occupancy flags and count
module jt12_bus_seq_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/jt12_bus_seq.sv
// jt12_bus_seq: queues {bank,reg,value} commands and replays each on the jt12
// bus as an address write, busy poll, data write, busy poll.
//   clk, rst              clock, asynchronous active-high reset
//   cmd_we/cmd_bank/cmd_reg/cmd_val/cmd_full/cmd_level  command queue
//   bus (master)          cs_n, wr_n, addr, dout out; din in (din[7] = busy)
//   idle                  FIFO empty and FSM idle (registered)
//   timeout / clr_to      sticky busy-timeout flag and its clear
//   state                 current FSM state, for observation
// Optional build macro JT12_BUS_SEQ_RANDWAIT_EN adds an LFSR-driven idle
// period of 0..15 cycles after each command.
module jt12_bus_seq
    import jt12_bus_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PULSE   = 2,
    parameter int GAP     = 1,
    parameter int BUSY_TO = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_we,
    input  logic                   cmd_bank,
    input  logic [7:0]             cmd_reg,
    input  logic [7:0]             cmd_val,
    output logic                   cmd_full,
    output logic [$clog2(DEPTH):0] cmd_level,
    jt12_bus_seq_if.master         bus,
    output logic                   idle,
    output logic                   timeout,
    input  logic                   clr_to,
    output state_t                 state
);
    localparam int CW  = 16;
    localparam int PCW = $clog2(BUSY_TO + 1);
    localparam logic [CW-1:0]  PULSE_LAST = CW'(PULSE - 1);
    localparam logic [CW-1:0]  GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [PCW-1:0] BUSY_LAST  = PCW'(BUSY_TO - 1);

    state_t         nxt;
    cmd_t           cur, cur_d, head, in_cmd;
    logic [CW-1:0]  cnt, cnt_d;
    logic [PCW-1:0] pcnt, pcnt_d;
    logic           pop, empty, push_ok, to_set;
    logic           cs_n_d, wr_n_d, idle_d;
    logic [1:0]     addr_d;
    logic [7:0]     dout_d;

    // Command handshake: a command is accepted on any rising edge where
    // cmd_we=1 and cmd_full=0; cmd_full acts as the inverse of ready.
    assign push_ok = cmd_we && !cmd_full;
    assign in_cmd  = '{bank: cmd_bank, regn: cmd_reg, val: cmd_val};

    jt12_bus_seq_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_we),
        .pop   (pop),
        .din   (in_cmd),
        .dout  (head),
        .full  (cmd_full),
        .empty (empty),
        .level (cmd_level)
    );

`ifdef JT12_BUS_SEQ_RANDWAIT_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
`endif

    always_comb begin
        nxt    = state;
        cur_d  = cur;
        cnt_d  = cnt;
        pcnt_d = pcnt;
        pop    = 1'b0;
        to_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    cur_d = head;
                    cnt_d = '0;
                    nxt   = S_AWR;
                end
            end
            S_AWR, S_DWR: begin
                if (cnt == PULSE_LAST) begin
                    cnt_d  = '0;
                    pcnt_d = '0;
                    if (GAP == 0) nxt = (state == S_AWR) ? S_POLL1 : S_POLL2;
                    else          nxt = (state == S_AWR) ? S_AGAP  : S_DGAP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_AGAP, S_DGAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d  = '0;
                    pcnt_d = '0;
                    nxt    = (state == S_AGAP) ? S_POLL1 : S_POLL2;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_POLL1, S_POLL2: begin
                // Each status read is two cycles; busy is sampled on the second.
                if (cnt == '0) begin
                    cnt_d = CW'(1);
                end else begin
                    cnt_d = '0;
                    if (!bus.din[7]) begin
                        if (state == S_POLL1) begin
                            nxt = S_DWR;
                        end else begin
`ifdef JT12_BUS_SEQ_RANDWAIT_EN
                            if (lfsr[3:0] != 4'd0) begin
                                nxt   = S_WAIT;
                                cnt_d = CW'(lfsr[3:0] - 4'd1);
                            end else begin
                                nxt = S_IDLE;
                            end
`else
                            nxt = S_IDLE;
`endif
                        end
                    end else if (pcnt == BUSY_LAST) begin
                        // Give up on this command; the next one starts fresh.
                        to_set = 1'b1;
                        nxt    = S_IDLE;
                    end else begin
                        pcnt_d = pcnt + 1'b1;
                    end
                end
            end
`ifdef JT12_BUS_SEQ_RANDWAIT_EN
            S_WAIT: begin
                if (cnt == '0) nxt = S_IDLE;
                else           cnt_d = cnt - 1'b1;
            end
`endif
            default: nxt = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state and registered, so the
        // strobes change exactly on state entry and never glitch.
        cs_n_d = !(nxt inside {S_AWR, S_POLL1, S_DWR, S_POLL2});
        wr_n_d = !(nxt inside {S_AWR, S_DWR});
        addr_d = bus.addr;
        dout_d = bus.dout;
        if (nxt == S_AWR) begin
            addr_d = {cur_d.bank, 1'b0};
            dout_d = cur_d.regn;
        end else if (nxt == S_DWR) begin
            addr_d = {cur_d.bank, 1'b1};
            dout_d = cur_d.val;
        end else if (nxt inside {S_POLL1, S_POLL2}) begin
            addr_d = 2'b00;
        end
        // A pop only happens when leaving IDLE, so only a push can refill here.
        idle_d = (nxt == S_IDLE) && empty && !push_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cur      <= '0;
            cnt      <= '0;
            pcnt     <= '0;
            bus.cs_n <= 1'b1;
            bus.wr_n <= 1'b1;
            bus.addr <= 2'b00;
            bus.dout <= 8'h00;
            idle     <= 1'b1;
            timeout  <= 1'b0;
        end else begin
            state    <= nxt;
            cur      <= cur_d;
            cnt      <= cnt_d;
            pcnt     <= pcnt_d;
            bus.cs_n <= cs_n_d;
            bus.wr_n <= wr_n_d;
            bus.addr <= addr_d;
            bus.dout <= dout_d;
            idle     <= idle_d;
            if (to_set)      timeout <= 1'b1;
            else if (clr_to) timeout <= 1'b0;
        end
    end
endmodule
